// File: rtl/fir_out_stage.sv
// FIR chain output stage: skips warm-up samples, rounds/saturates to OUT_WIDTH, tags, and buffers in a show-ahead FIFO.
// Latency 1 clk i_en->o_valid; on full FIFO with no pop the sample is dropped. Optional FIR_OUT_STATS_EN adds sat/drop counters.
module fir_out_stage #(
  parameter int DATA_WIDTH = 24,
  parameter int OUT_WIDTH  = 16,
  parameter int NUM_TAPS   = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          i_clk,
  input  logic                          i_rst_n,
  input  logic                          i_en,
  input  logic [DATA_WIDTH-1:0]         iv_sum,
  input  logic [NUM_TAPS-1:0]           iv_prod_ovf,
  input  logic [NUM_TAPS-1:0]           iv_sum_ovf,
  input  logic                          i_clr_ovf,
  input  logic                          i_ready,
  output logic                          o_valid,
  output logic [OUT_WIDTH-1:0]          ov_dout,
  output logic                          o_sat,
  output logic                          o_full,
  output logic [$clog2(FIFO_DEPTH):0]   ov_count,
  output logic                          o_fifo_ovf
`ifdef FIR_OUT_STATS_EN
  ,
  output logic [15:0]                   ov_sat_cnt,
  output logic [15:0]                   ov_drop_cnt
`endif
);

  localparam int SHIFT = DATA_WIDTH - OUT_WIDTH;
  localparam int AW    = $clog2(FIFO_DEPTH);
  localparam int CW    = AW + 1;
  localparam int WCW   = (NUM_TAPS > 2) ? $clog2(NUM_TAPS) : 1;

  localparam logic [DATA_WIDTH:0] HALF      = {{DATA_WIDTH{1'b0}}, 1'b1} << (SHIFT - 1);
  localparam logic [WCW-1:0]      WARM_LAST = WCW'(NUM_TAPS - 2);
  localparam logic [CW-1:0]       DEPTH_C   = CW'(FIFO_DEPTH);

  typedef enum logic {FILL, RUN} state_e;

  state_e               state_q;
  logic [WCW-1:0]       warm_q;
  logic [OUT_WIDTH:0]   mem_q [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]        count_q, count_d;
  logic                 ovf_q;

  logic [DATA_WIDTH:0]  rnd;
  logic [OUT_WIDTH:0]   qv;
  logic [OUT_WIDTH-1:0] sample;
  logic                 sat_hit, tag;
  logic                 push, pop, wr_en, drop;

  // Round half up, then clamp: the top two bits of q disagree exactly when it exceeds OUT_WIDTH range.
  always_comb begin
    rnd     = {iv_sum[DATA_WIDTH-1], iv_sum} + HALF;
    qv      = rnd[DATA_WIDTH:SHIFT];
    sat_hit = qv[OUT_WIDTH] ^ qv[OUT_WIDTH-1];
    sample  = qv[OUT_WIDTH-1:0];
    if (sat_hit) begin
      sample = qv[OUT_WIDTH] ? {1'b1, {(OUT_WIDTH-1){1'b0}}} : {1'b0, {(OUT_WIDTH-1){1'b1}}};
    end
    tag = sat_hit | (|iv_prod_ovf) | (|iv_sum_ovf);
  end

  assign o_valid    = (count_q != '0);
  assign o_full     = (count_q == DEPTH_C);
  assign ov_count   = count_q;
  assign o_fifo_ovf = ovf_q;
  assign ov_dout    = mem_q[rd_ptr_q][OUT_WIDTH-1:0];
  assign o_sat      = mem_q[rd_ptr_q][OUT_WIDTH];

  assign push  = (state_q == RUN) && i_en;
  assign pop   = o_valid && i_ready;
  assign wr_en = push && (!o_full || pop);
  assign drop  = push && o_full && !pop;

  always_comb begin
    count_d = count_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= FILL;
      warm_q  <= '0;
    end else if (state_q == FILL && i_en) begin
      warm_q <= warm_q + WCW'(1);
      if (warm_q == WARM_LAST) begin
        state_q <= RUN;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      ovf_q    <= 1'b0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      if (wr_en) begin
        mem_q[wr_ptr_q] <= {tag, sample};
        wr_ptr_q        <= wr_ptr_q + AW'(1);
      end
      if (pop) begin
        rd_ptr_q <= rd_ptr_q + AW'(1);
      end
      count_q <= count_d;
      // A drop in the same cycle as a clear must stay visible.
      if (drop) begin
        ovf_q <= 1'b1;
      end else if (i_clr_ovf) begin
        ovf_q <= 1'b0;
      end
    end
  end

`ifdef FIR_OUT_STATS_EN
  logic [15:0] sat_cnt_q, drop_cnt_q;

  assign ov_sat_cnt  = sat_cnt_q;
  assign ov_drop_cnt = drop_cnt_q;

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      sat_cnt_q  <= '0;
      drop_cnt_q <= '0;
    end else begin
      if (wr_en && tag) begin
        if (sat_cnt_q != 16'hFFFF) sat_cnt_q <= sat_cnt_q + 16'd1;
      end else if (i_clr_ovf) begin
        sat_cnt_q <= '0;
      end
      if (drop) begin
        if (drop_cnt_q != 16'hFFFF) drop_cnt_q <= drop_cnt_q + 16'd1;
      end else if (i_clr_ovf) begin
        drop_cnt_q <= '0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_fir_out_stage.sv
// Bench for fir_out_stage (NUM_TAPS=4, FIFO_DEPTH=4): directed pushes feed an expected-output queue, a monitor checks pops.
module tb_fir_out_stage;

  logic        clk = 1'b0;
  logic        i_rst_n, i_en, i_clr_ovf, i_ready;
  logic [23:0] iv_sum;
  logic [3:0]  iv_prod_ovf, iv_sum_ovf;
  logic        o_valid, o_sat, o_full, o_fifo_ovf;
  logic [15:0] ov_dout;
  logic [2:0]  ov_count;
`ifdef FIR_OUT_STATS_EN
  logic [15:0] ov_sat_cnt, ov_drop_cnt;
`endif

  int checks   = 0;
  int failures = 0;
  logic [16:0] exp_q[$];

  always #5 clk = ~clk;

  fir_out_stage #(.DATA_WIDTH(24), .OUT_WIDTH(16), .NUM_TAPS(4), .FIFO_DEPTH(4)) dut (
    .i_clk(clk), .i_rst_n(i_rst_n), .i_en(i_en), .iv_sum(iv_sum),
    .iv_prod_ovf(iv_prod_ovf), .iv_sum_ovf(iv_sum_ovf), .i_clr_ovf(i_clr_ovf),
    .i_ready(i_ready), .o_valid(o_valid), .ov_dout(ov_dout), .o_sat(o_sat),
    .o_full(o_full), .ov_count(ov_count), .o_fifo_ovf(o_fifo_ovf)
`ifdef FIR_OUT_STATS_EN
    , .ov_sat_cnt(ov_sat_cnt), .ov_drop_cnt(ov_drop_cnt)
`endif
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [23:0] s, input logic [3:0] po, input logic [3:0] so,
                      input logic store, input logic [15:0] d, input logic st);
    iv_sum = s;
    iv_prod_ovf = po;
    iv_sum_ovf = so;
    i_en = 1'b1;
    if (store) exp_q.push_back({st, d});
    tick();
    i_en = 1'b0;
    iv_sum = '0;
    iv_prod_ovf = '0;
    iv_sum_ovf = '0;
  endtask

  task automatic drain();
    i_ready = 1'b1;
    for (int i = 0; i < 20 && ov_count != 3'd0; i++) tick();
    i_ready = 1'b0;
    chk("drain_empty", {29'd0, ov_count}, 32'd0);
  endtask

  // Every accepted pop is compared against the oldest outstanding expectation.
  always @(negedge clk) begin
    if (i_rst_n === 1'b1 && o_valid === 1'b1 && i_ready === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL pop_unexpected: got %0h expected no output", {o_sat, ov_dout});
      end else begin
        logic [16:0] e;
        e = exp_q.pop_front();
        if ({o_sat, ov_dout} !== e) begin
          failures++;
          $display("FAIL pop_data: got sat=%0b dout=%0h expected sat=%0b dout=%0h",
                   o_sat, ov_dout, e[16], e[15:0]);
        end
      end
    end
  end

  initial begin
    #200000;
    failures++;
    $display("FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1);
  end

  initial begin
    i_rst_n = 1'b0; i_en = 1'b0; i_clr_ovf = 1'b0; i_ready = 1'b0;
    iv_sum = '0; iv_prod_ovf = '0; iv_sum_ovf = '0;
    tick(); tick();
    chk("rst_valid", {31'd0, o_valid}, 32'd0);
    chk("rst_dout",  {16'd0, ov_dout}, 32'd0);
    chk("rst_sat",   {31'd0, o_sat}, 32'd0);
    chk("rst_full",  {31'd0, o_full}, 32'd0);
    chk("rst_count", {29'd0, ov_count}, 32'd0);
    chk("rst_ovf",   {31'd0, o_fifo_ovf}, 32'd0);
    i_rst_n = 1'b1;
    tick();

    // Warm-up: three strobes are swallowed.
    for (int i = 0; i < 3; i++) send(24'h7FFFFF, 4'hF, 4'hF, 1'b0, 16'h0, 1'b0);
    chk("warm_valid", {31'd0, o_valid}, 32'd0);
    send(24'h000180, 4'h0, 4'h0, 1'b1, 16'h0002, 1'b0);
    chk("first_valid", {31'd0, o_valid}, 32'd1);
    chk("first_dout",  {16'd0, ov_dout}, 32'h0002);
    chk("first_count", {29'd0, ov_count}, 32'd1);
    drain();

    // Rounding, saturation and tap-flag tagging with the consumer always ready.
    i_ready = 1'b1;
    send(24'h7FFFFF, 4'h0, 4'h0, 1'b1, 16'h7FFF, 1'b1);
    send(24'h800000, 4'h0, 4'h0, 1'b1, 16'h8000, 1'b0);
    send(24'h000100, 4'h0, 4'b0100, 1'b1, 16'h0001, 1'b1);
    send(24'h000080, 4'b0001, 4'h0, 1'b1, 16'h0001, 1'b1);
    send(24'hFFFF80, 4'h0, 4'h0, 1'b1, 16'h0000, 1'b0);
    send(24'hFFFF7F, 4'h0, 4'h0, 1'b1, 16'hFFFF, 1'b0);
    send(24'h7FFF7F, 4'h0, 4'h0, 1'b1, 16'h7FFF, 1'b0);
    drain();

    // Overflow: fifth push lands on a full FIFO and is dropped.
    for (int i = 1; i <= 5; i++) send(24'(i) << 8, 4'h0, 4'h0, (i <= 4), 16'(i), 1'b0);
    chk("ovf_count", {29'd0, ov_count}, 32'd4);
    chk("ovf_full",  {31'd0, o_full}, 32'd1);
    chk("ovf_flag",  {31'd0, o_fifo_ovf}, 32'd1);
    drain();
    chk("ovf_sticky", {31'd0, o_fifo_ovf}, 32'd1);
    i_clr_ovf = 1'b1;
    tick();
    i_clr_ovf = 1'b0;
    chk("ovf_clr", {31'd0, o_fifo_ovf}, 32'd0);

    // Full FIFO with simultaneous push and pop: nothing dropped.
    for (int i = 0; i < 4; i++) send(24'(16 + i) << 8, 4'h0, 4'h0, 1'b1, 16'(16 + i), 1'b0);
    chk("sim_full", {31'd0, o_full}, 32'd1);
    i_ready = 1'b1;
    send(24'h002000, 4'h0, 4'h0, 1'b1, 16'h0020, 1'b0);
    i_ready = 1'b0;
    chk("sim_count", {29'd0, ov_count}, 32'd4);
    chk("sim_ovf",   {31'd0, o_fifo_ovf}, 32'd0);
    drain();

    // Mid-stream reset discards contents and re-enters warm-up.
    for (int i = 0; i < 3; i++) send(24'h000500, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("pre_rst_count", {29'd0, ov_count}, 32'd3);
    i_rst_n = 1'b0;
    tick();
    chk("mid_rst_valid", {31'd0, o_valid}, 32'd0);
    chk("mid_rst_count", {29'd0, ov_count}, 32'd0);
    chk("mid_rst_dout",  {16'd0, ov_dout}, 32'd0);
    i_rst_n = 1'b1;
    for (int i = 0; i < 3; i++) send(24'h000500, 4'h0, 4'h0, 1'b0, 16'h0, 1'b0);
    chk("rewarm_count", {29'd0, ov_count}, 32'd0);
    send(24'h000300, 4'h0, 4'h0, 1'b1, 16'h0003, 1'b0);
    chk("rewarm_push", {29'd0, ov_count}, 32'd1);
    drain();

    tick();
    chk("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
